// File: rtl/dmem_bridge_if.sv
// dmem_bridge_if: LSU strobe and data-bus request/response signals of the data-memory bridge.
interface dmem_bridge_if;
    logic        mem_ce;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [3:0]  mem_sel;
    logic [31:0] mem_wdata;
    logic        flush;
    logic [31:0] mem_rdata;
    logic        stall_req;
    logic        bus_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        bus_rerr;
    modport master (
        input  mem_ce, mem_we, mem_a, mem_sel, mem_wdata, flush,
        input  bus_ack, bus_rvalid, bus_rdata, bus_rerr,
        output mem_rdata, stall_req, bus_err,
        output bus_req, bus_we, bus_addr, bus_sel, bus_wdata
    );
    modport slave (
        output mem_ce, mem_we, mem_a, mem_sel, mem_wdata, flush,
        output bus_ack, bus_rvalid, bus_rdata, bus_rerr,
        input  mem_rdata, stall_req, bus_err,
        input  bus_req, bus_we, bus_addr, bus_sel, bus_wdata
    );
endinterface

// File: rtl/dmem_bridge.sv
// dmem_bridge: turns the LSU memory strobe into a req/ack/response bus transaction,
// stalling the pipeline until the response, with response timeout and flush discard.
module dmem_bridge #(
    parameter int TIMEOUT = 255
) (
    input logic          clk,
    input logic          rst_n,
    dmem_bridge_if.master b
);
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
    state_t        st;
    logic          lwe;
    logic [31:0]   la;
    logic [3:0]    lsel;
    logic [31:0]   lwd;
    logic [31:0]   rbuf;
    logic          err_q;
    logic          disc;
    logic [CW-1:0] cnt;
    logic          go;
    logic          tmo;
    logic          fin;
    always_comb begin
        go = (st == IDLE) & b.mem_ce & ~b.flush;
        tmo = TIMEOUT != 0 && int'(cnt) == TIMEOUT - 1;
        fin = (st == RESP) & (b.bus_rvalid | tmo);
        b.bus_req = go | (st == REQ);
        b.bus_we = go ? b.mem_we : (st == REQ) & lwe;
        b.bus_addr = go ? b.mem_a : (st == REQ) ? la : '0;
        b.bus_sel = go ? b.mem_sel : (st == REQ) ? lsel : '0;
        b.bus_wdata = go ? b.mem_wdata : (st == REQ) ? lwd : '0;
        b.stall_req = go | (st == REQ) | (st == RESP);
        b.bus_err = err_q;
        b.mem_rdata = rbuf;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st    <= IDLE;
            lwe   <= 1'b0;
            la    <= '0;
            lsel  <= '0;
            lwd   <= '0;
            rbuf  <= '0;
            err_q <= 1'b0;
            disc  <= 1'b0;
            cnt   <= '0;
        end else begin
            err_q <= 1'b0;
            cnt   <= (st == RESP) ? cnt + 1'b1 : '0;
            unique case (st)
                IDLE: if (go) begin
                    lwe  <= b.mem_we;
                    la   <= b.mem_a;
                    lsel <= b.mem_sel;
                    lwd  <= b.mem_wdata;
                    st   <= b.bus_ack ? RESP : REQ;
                end
                REQ: begin
                    if (b.flush) disc <= 1'b1;
                    if (b.bus_ack) st <= RESP;
                end
                RESP: begin
                    if (b.flush) disc <= 1'b1;
                    // a flush arriving with the response still discards it
                    if (fin) begin
                        rbuf  <= (b.bus_rvalid & ~b.bus_rerr) ? b.bus_rdata : '0;
                        err_q <= ~(disc | b.flush) & (~b.bus_rvalid | b.bus_rerr);
                        st    <= (disc | b.flush) ? IDLE : DONE;
                        disc  <= 1'b0;
                    end
                end
                DONE: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: randomized transaction-timeline checks of dmem_bridge against a
// cycle-schedule reference derived from ack delay, response delay, timeout and flush.
module tb_dmem_bridge;
    localparam int TO = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    dmem_bridge_if bif();
    dmem_bridge #(.TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .b(bif));
    int n_tests = 0;
    int n_fail = 0;
    logic [31:0] buf_exp = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit ce, input bit fl, input bit ack, input bit rv, input bit re,
                         input logic [31:0] rd);
        bif.mem_ce = ce;
        bif.mem_we = 1'($urandom);
        bif.mem_a = $urandom;
        bif.mem_sel = 4'($urandom);
        bif.mem_wdata = $urandom;
        bif.flush = fl;
        bif.bus_ack = ack;
        bif.bus_rvalid = rv;
        bif.bus_rerr = re;
        bif.bus_rdata = rd;
    endtask

    // inputs already driven at posedge+1; check mid-cycle, then advance to next posedge+1
    task automatic expect_cyc(input string ph, input bit req, input bit we, input logic [31:0] a,
                              input logic [3:0] sel, input logic [31:0] wd, input bit stall,
                              input bit err);
        #4;
        chk({ph, " req"}, 32'(bif.bus_req), 32'(req));
        chk({ph, " we"}, 32'(bif.bus_we), 32'(we));
        chk({ph, " addr"}, bif.bus_addr, a);
        chk({ph, " sel"}, 32'(bif.bus_sel), 32'(sel));
        chk({ph, " wdata"}, bif.bus_wdata, wd);
        chk({ph, " stall"}, 32'(bif.stall_req), 32'(stall));
        chk({ph, " err"}, 32'(bif.bus_err), 32'(err));
        chk({ph, " rdata"}, bif.mem_rdata, buf_exp);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cyc();
        drive(1'b0, 1'b0, 1'b0, 1'($urandom), 1'b0, $urandom);
        expect_cyc("idle", 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    // a: ack delay, r: rvalid cycles after ack (0 = never), fl: flush cycle (-1 none)
    task automatic run_txn(input int a, input int r, input bit err, input int fl, input bit fl_done,
                           input bit we, input logic [31:0] ad, input logic [3:0] sel,
                           input logic [31:0] wd, input logic [31:0] rd);
        bit ok = r > 0 && r <= TO;
        int kc = a + (ok ? r : TO);
        bit disc = fl >= 1 && fl <= kc;
        logic [31:0] nb = (ok && !err) ? rd : '0;
        bit ne = !ok || err;
        for (int k = 0; k <= kc; k++) begin
            bit rv = (r > 0 && k == a + r) || (k <= a && $urandom_range(1) == 1);
            drive(1'b1, k == fl, k == a, rv, err, (r > 0 && k == a + r) ? rd : $urandom);
            if (k == 0) begin
                bif.mem_we = we;
                bif.mem_a = ad;
                bif.mem_sel = sel;
                bif.mem_wdata = wd;
            end
            if (k <= a) expect_cyc("req", 1'b1, we, ad, sel, wd, 1'b1, 1'b0);
            else expect_cyc("resp", 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
        end
        buf_exp = nb;
        if (!disc) begin
            drive(1'b1, fl_done, 1'b0, 1'($urandom), 1'b0, $urandom);
            expect_cyc("done", 1'b0, 1'b0, '0, '0, '0, 1'b0, ne);
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst stall", 32'(bif.stall_req), 0);
        chk("rst req", 32'(bif.bus_req), 0);
        chk("rst err", 32'(bif.bus_err), 0);
        chk("rst rdata", bif.mem_rdata, 0);
        rst_n = 1'b1;
        idle_cyc();
        run_txn(0, 1, 1'b0, -1, 1'b0, 1'b0, 32'h100, 4'hF, $urandom, 32'hDEADBEEF);
        run_txn(3, 2, 1'b0, -1, 1'b0, 1'b1, 32'h204, 4'h3, 32'h12345678, $urandom);
        run_txn(0, 0, 1'b0, -1, 1'b0, 1'b0, $urandom, 4'hF, $urandom, $urandom);
        run_txn(1, 1, 1'b1, -1, 1'b0, 1'b0, $urandom, 4'hF, $urandom, 32'hFFFFFFFF);
        run_txn(2, 1, 1'b0, 1, 1'b0, 1'b0, 32'h300, 4'hF, $urandom, 32'hCAFEF00D);
        run_txn(0, 1, 1'b0, -1, 1'b1, 1'b0, 32'h304, 4'hF, $urandom, 32'h0BADF00D);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, $urandom);
        expect_cyc("idle flush", 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
        idle_cyc();
        for (int i = 0; i < 60; i++) begin
            int a = $urandom_range(0, 4);
            int fl = ($urandom_range(0, 3) == 0) ? $urandom_range(1, a + 2) : -1;
            run_txn(a, $urandom_range(0, 6), $urandom_range(0, 3) == 0, fl, 1'($urandom),
                    1'($urandom), $urandom, 4'($urandom), $urandom, $urandom);
            repeat ($urandom_range(0, 2)) idle_cyc();
        end
        run_txn(0, 1, 1'b0, -1, 1'b0, 1'b0, 32'h400, 4'hF, $urandom, 32'h5A5A5A5A);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, $urandom);
        bif.mem_we = 1'b0;
        expect_cyc("pre-rst req", 1'b1, 1'b0, bif.mem_a, bif.mem_sel, bif.mem_wdata, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, $urandom);
        #1 rst_n = 1'b0;
        #1;
        buf_exp = '0;
        chk("async stall", 32'(bif.stall_req), 0);
        chk("async req", 32'(bif.bus_req), 0);
        chk("async err", 32'(bif.bus_err), 0);
        chk("async rdata", bif.mem_rdata, 0);
        chk("async addr", bif.bus_addr, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) idle_cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Data-memory bus bridge sitting directly downstream of the LSU (`mem`) stage. Converts the LSU's single-cycle memory strobe (chip-enable, write-enable, address, byte-select, write data) into a request/acknowledge/response transaction on the data bus. While a transaction is outstanding it holds the pipeline through `stall_req_o`, then returns read data to the LSU for exactly one cycle. Also provides a response timeout and flush-safe cancellation.

## Interface
- `TIMEOUT`, 255: number of RESP-state cycles without `bus_rvalid_i` before a bus error is forced; 0 disables the timeout.
- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `n_rst_i`  in  1  reset; asynchronous, active-low.
- `mem_ce_i`  in  1  LSU access strobe.
- `mem_we_i`  in  1  1 = store, 0 = load.
- `mem_a_i`  in  32  byte address.
- `mem_sel_i`  in  4  byte lane select.
- `mem_wdata_i`  in  32  store data, already lane-replicated by the LSU.
- `flush_i`  in  1  ctrl flush of the mem-stage instruction.
- `mem_rdata_o`  out  32  read data to the LSU.
- `stall_req_o`  out  1  pipeline stall request to ctrl.
- `bus_err_o`  out  1  one-cycle pulse when an access completes with an error or timeout.
- `bus_req_o`  out  1  bus request valid.
- `bus_we_o`  out  1  bus write.
- `bus_addr_o`  out  32  bus address.
- `bus_sel_o`  out  4  bus byte enables.
- `bus_wdata_o`  out  32  bus write data.
- `bus_ack_i`  in  1  request accepted by the slave in this cycle.
- `bus_rvalid_i`  in  1  response valid (reads and writes both respond).
- `bus_rdata_i`  in  32  response data.
- `bus_err_i`  in  1  response error; qualified by `bus_rvalid_i`.

## Operation
- **States:** IDLE, REQ, RESP, DONE.
- **IDLE**
  - With `mem_ce_i & ~flush_i`: `bus_req_o`=1, driven combinationally from the live `mem_*` inputs. All request fields are captured into a request latch.
  - If `bus_ack_i` is high in the same cycle → RESP; otherwise → REQ.
  - `stall_req_o` = `mem_ce_i & ~flush_i`.
- **REQ**
  - `bus_req_o`=1, with bus fields driven from the latch and held stable until `bus_ack_i`.
  - `bus_ack_i` → RESP. A request is never withdrawn.
- **RESP**
  - `bus_req_o`=0. The timeout counter increments each cycle.
  - `bus_rvalid_i` → capture `bus_rdata_i` (0 if `bus_err_i`) into the response buffer, latch the error flag, go to DONE.
  - If the counter reaches `TIMEOUT` with no `bus_rvalid_i` → buffer 0, error flag 1, go to DONE.
- **DONE**
  - `stall_req_o`=0 and `mem_rdata_o` = buffer, so the pipeline advances at the end of this cycle.
  - `bus_err_o` = error flag.
  - `mem_ce_i` is ignored (it is still the same instruction). Always → IDLE.
- **Discard flag**
  - Set by `flush_i` in REQ or RESP.
  - With the flag set, the transaction still completes on the bus, but RESP exits straight to IDLE, with no DONE cycle and no `bus_err_o`.
  - Cleared on entry to IDLE.
- **Stall:** `stall_req_o`=1 throughout REQ and RESP, regardless of `flush_i`.
- **Output holding:** `mem_rdata_o` holds the last buffered value outside DONE. In IDLE, when not requesting, the bus fields are 0.
- **Timeout counter:** width `$clog2(TIMEOUT+1)`; cleared on entry to RESP. With `TIMEOUT`=0, RESP waits indefinitely.

## Timing
- **Reset (`n_rst_i`=0):** all outputs 0, state IDLE, latch/buffer/flags/counter 0. Takes effect immediately, including mid-transaction. The bus slave shares the same reset.
- **Minimum access:** ack in issue cycle C0, `bus_rvalid_i` in C1, DONE in C2.
  - `stall_req_o` high in C0 and C1, low in C2.
  - The LSU sees data in C2.
- **Response ordering:** `bus_rvalid_i` is never accepted in the same cycle as `bus_ack_i`. The slave guarantees a response at least one cycle after ack; an `rvalid` outside RESP is ignored.
- **Back-to-back:** the next access is issued at the earliest in the cycle after DONE (IDLE).
- **Flush in IDLE:** flush together with `mem_ce_i` issues nothing.
- **Flush in DONE:** no effect; the access has already completed.

## Test plan
- **Fast load:** `mem_ce_i`=1, `we`=0, addr 0x100, `sel` 1111; slave acks in C0 and responds 0xDEADBEEF in C1 → `bus_req_o` only in C0, stall 1,1,0; `mem_rdata_o`=0xDEADBEEF in C2, `bus_err_o`=0.
- **Delayed ack store:** store of 0x12345678 to 0x204, `sel` 0011; ack withheld 3 cycles, then `rvalid` 2 cycles after ack → `bus_addr_o`/`bus_sel_o`/`bus_wdata_o` stable across all REQ cycles, even though the `mem_*` inputs change; stall is high for 6 cycles, then DONE.
- **Timeout:** `TIMEOUT`=4; ack given, `rvalid` never asserted → DONE after 4 RESP cycles, `mem_rdata_o`=0, `bus_err_o` pulsed once.
- **Bus error:** `rvalid`=1 with `bus_err_i`=1 and `rdata` 0xFFFFFFFF → `mem_rdata_o`=0, `bus_err_o`=1 for one cycle.
- **Flush mid-flight:**
  - `flush_i` in the first REQ cycle, ack 2 cycles later, then `rvalid` → stall stays high until the response, then goes straight to IDLE: no DONE, no error pulse.
  - A new `mem_ce_i` on the following cycle issues normally.
- **Async reset:** assert `n_rst_i`=0 in RESP → all outputs 0 immediately, state IDLE. After release with `mem_ce_i`=0 → no bus activity.
